// File: rtl/sd_cmd_arbiter.sv
// Round-robin arbiter sharing the SD command PHY between the host port (0)
// and the DMA engine (1), with a response/ack watchdog that aborts the PHY.
module sd_cmd_arbiter #(
  parameter int CMD_W          = 48,
  parameter int RSP_W          = 38,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             iClock_SD,
  input  logic             iReset_n,
  input  logic             iReq0,
  input  logic             iReq1,
  input  logic [CMD_W-1:0] iCmd0,
  input  logic [CMD_W-1:0] iCmd1,
  output logic             oGnt0,
  output logic             oGnt1,
  output logic             oDone0,
  output logic             oDone1,
  output logic [RSP_W-1:0] oResp,
  output logic             oTimeout,
  output logic             oPhy_strobe,
  output logic [CMD_W-1:0] oPhy_cmd,
  input  logic             iPhy_strobe,
  input  logic [RSP_W-1:0] iPhy_response,
  output logic             oPhy_ack,
  input  logic             iPhy_ack,
  output logic             oPhy_reset
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_RESP, WAIT_ACK, ABORT, DONE
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] count, count_d;
  logic             last_gnt, last_gnt_d;
  logic [RSP_W-1:0] rsp_q, rsp_d;
  logic             gnt0_d, gnt1_d, done0_d, done1_d;
  logic [RSP_W-1:0] resp_d;
  logic             timeout_d, strobe_d, ack_d, reset_d;
  logic [CMD_W-1:0] cmd_d;
  logic             win1, expired;

  // On contention the requester that did not win last time is served.
  assign win1    = iReq1 & (~iReq0 | ~last_gnt);
  assign expired = (count == LIM);

  always_comb begin
    state_d    = state;
    count_d    = count;
    last_gnt_d = last_gnt;
    rsp_d      = rsp_q;
    gnt0_d     = oGnt0;
    gnt1_d     = oGnt1;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    resp_d     = oResp;
    timeout_d  = oTimeout;
    strobe_d   = 1'b0;
    cmd_d      = oPhy_cmd;
    ack_d      = 1'b0;
    reset_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (iReq0 | iReq1) begin
          state_d    = ISSUE;
          strobe_d   = 1'b1;
          gnt0_d     = ~win1;
          gnt1_d     = win1;
          cmd_d      = win1 ? iCmd1 : iCmd0;
          last_gnt_d = win1;
        end
      end
      ISSUE: begin
        state_d = WAIT_RESP;
        count_d = '0;
      end
      WAIT_RESP: begin
        count_d = count + 1'b1;
        if (iPhy_strobe) begin
          state_d = WAIT_ACK;
          count_d = '0;
          rsp_d   = iPhy_response;
          ack_d   = 1'b1;
        end else if (expired) begin
          state_d = ABORT;
          rsp_d   = '0;
          reset_d = 1'b1;
        end
      end
      WAIT_ACK: begin
        count_d = count + 1'b1;
        ack_d   = 1'b1;
        if (iPhy_ack) begin
          state_d   = DONE;
          ack_d     = 1'b0;
          done0_d   = oGnt0;
          done1_d   = oGnt1;
          resp_d    = rsp_q;
          timeout_d = 1'b0;
        end else if (expired) begin
          state_d = ABORT;
          ack_d   = 1'b0;
          rsp_d   = '0;
          reset_d = 1'b1;
        end
      end
      ABORT: begin
        state_d   = DONE;
        done0_d   = oGnt0;
        done1_d   = oGnt1;
        resp_d    = '0;
        timeout_d = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClock_SD or negedge iReset_n) begin
    if (!iReset_n) begin
      state       <= IDLE;
      count       <= '0;
      last_gnt    <= 1'b1;
      rsp_q       <= '0;
      oGnt0       <= 1'b0;
      oGnt1       <= 1'b0;
      oDone0      <= 1'b0;
      oDone1      <= 1'b0;
      oResp       <= '0;
      oTimeout    <= 1'b0;
      oPhy_strobe <= 1'b0;
      oPhy_cmd    <= '0;
      oPhy_ack    <= 1'b0;
      oPhy_reset  <= 1'b0;
    end else begin
      state       <= state_d;
      count       <= count_d;
      last_gnt    <= last_gnt_d;
      rsp_q       <= rsp_d;
      oGnt0       <= gnt0_d;
      oGnt1       <= gnt1_d;
      oDone0      <= done0_d;
      oDone1      <= done1_d;
      oResp       <= resp_d;
      oTimeout    <= timeout_d;
      oPhy_strobe <= strobe_d;
      oPhy_cmd    <= cmd_d;
      oPhy_ack    <= ack_d;
      oPhy_reset  <= reset_d;
    end
  end

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Scoreboard bench for sd_cmd_arbiter: directed transactions, queued
// expectations popped by a monitor on command strobes and done pulses.
module tb_sd_cmd_arbiter;

  localparam int CMD_W = 48;
  localparam int RSP_W = 38;

  logic             clk;
  logic             rst_n;
  logic             req0, req1;
  logic [CMD_W-1:0] cmd0, cmd1;
  logic             gnt0, gnt1, done0, done1;
  logic [RSP_W-1:0] resp;
  logic             tmo;
  logic             p_strobe;
  logic [CMD_W-1:0] p_cmd;
  logic             ph_strobe;
  logic [RSP_W-1:0] ph_resp;
  logic             p_ack;
  logic             ph_ack;
  logic             p_reset;

  sd_cmd_arbiter #(
    .CMD_W(CMD_W),
    .RSP_W(RSP_W),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .iClock_SD(clk),
    .iReset_n(rst_n),
    .iReq0(req0),
    .iReq1(req1),
    .iCmd0(cmd0),
    .iCmd1(cmd1),
    .oGnt0(gnt0),
    .oGnt1(gnt1),
    .oDone0(done0),
    .oDone1(done1),
    .oResp(resp),
    .oTimeout(tmo),
    .oPhy_strobe(p_strobe),
    .oPhy_cmd(p_cmd),
    .iPhy_strobe(ph_strobe),
    .iPhy_response(ph_resp),
    .oPhy_ack(p_ack),
    .iPhy_ack(ph_ack),
    .oPhy_reset(p_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             w;
    logic [CMD_W-1:0] cmd;
  } iss_t;

  typedef struct {
    logic             w;
    logic [RSP_W-1:0] rsp;
    logic             tmo;
  } dn_t;

  iss_t iq[$];
  dn_t  dq[$];
  int   tests = 0;
  int   fails = 0;
  int   rst_pulses = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired or event unexpected", name);
  endtask

  // Monitor: pops expectations whenever the DUT strobes or completes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (p_reset) rst_pulses++;
      if (p_strobe) begin
        if (iq.size() == 0) fail_now("issue_unexpected");
        else begin
          iss_t e;
          e = iq.pop_front();
          check("issue_cmd", 64'(p_cmd), 64'(e.cmd));
          check("issue_gnt", 64'({gnt1, gnt0}),
                e.w ? 64'd2 : 64'd1);
        end
      end
      if (done0 | done1) begin
        if (dq.size() == 0) fail_now("done_unexpected");
        else begin
          dn_t d;
          d = dq.pop_front();
          check("done_who", 64'({done1, done0}),
                d.w ? 64'd2 : 64'd1);
          check("done_gnt", 64'({gnt1, gnt0}),
                d.w ? 64'd2 : 64'd1);
          check("done_resp", 64'(resp), 64'(d.rsp));
          check("done_tmo", 64'(tmo), 64'(d.tmo));
        end
      end
    end
  end

  task automatic push(input logic w, input logic [CMD_W-1:0] c,
                      input logic [RSP_W-1:0] r, input logic t);
    iss_t e;
    dn_t  d;
    e.w = w; e.cmd = c;
    d.w = w; d.rsp = r; d.tmo = t;
    iq.push_back(e);
    dq.push_back(d);
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    while (!p_strobe && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!p_strobe) fail_now("strobe_wait");
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(done0 | done1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(done0 | done1)) fail_now("done_wait");
  endtask

  // PHY model: response rd negedges after ISSUE, ack ad cycles into WAIT_ACK.
  task automatic phy(input int rd, input logic [RSP_W-1:0] r,
                     input int ad, input bit do_ack);
    int n;
    wait_strobe(n);
    repeat (rd) @(negedge clk);
    ph_strobe = 1'b1;
    ph_resp   = r;
    @(negedge clk);
    ph_strobe = 1'b0;
    if (do_ack) begin
      repeat (ad - 1) @(negedge clk);
      ph_ack = 1'b1;
      @(negedge clk);
      ph_ack = 1'b0;
    end
  endtask

  localparam logic [CMD_W-1:0] CA = 48'h40_0000_0000_95;
  localparam logic [CMD_W-1:0] CB = 48'h51_0000_1000_FF;
  localparam logic [CMD_W-1:0] CC = 48'h4C_0000_0002_33;

  initial begin
    int n;
    int rp;
    logic [RSP_W-1:0] rs [4];
    rs[0] = 38'h00_AAAA_0001;
    rs[1] = 38'h11_BBBB_0002;
    rs[2] = 38'h22_CCCC_0003;
    rs[3] = 38'h33_DDDD_0004;

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    cmd0 = CA; cmd1 = CB;
    ph_strobe = 1'b0; ph_ack = 1'b0; ph_resp = '0;
    #12;
    check("rst_ctrl", 64'({gnt0, gnt1, done0, done1, tmo,
                           p_strobe, p_ack, p_reset}), 64'd0);
    check("rst_resp", 64'(resp), 64'd0);
    check("rst_cmd", 64'(p_cmd), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // PHY strobes while idle must be ignored
    ph_strobe = 1'b1; ph_ack = 1'b1; ph_resp = 38'h3F_FFFF_FFFF;
    @(negedge clk);
    ph_strobe = 1'b0; ph_ack = 1'b0;
    @(negedge clk);
    check("idle_ignore", 64'({p_strobe, p_ack, gnt0, gnt1, done0, done1}),
          64'd0);

    // contention from reset: alternates 0,1,0,1
    cmd0 = CC;
    push(1'b0, CC, rs[0], 1'b0);
    push(1'b1, CB, rs[1], 1'b0);
    push(1'b0, CC, rs[2], 1'b0);
    push(1'b1, CB, rs[3], 1'b0);
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      phy(2, rs[k], 1, 1'b1);
      wait_done();
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    @(negedge clk);
    check("idle_gnt_clear", 64'({gnt1, gnt0}), 64'd0);

    // single request, response 3 cycles after ISSUE
    cmd0 = CA;
    push(1'b0, CA, 38'h01_2345_6789, 1'b0);
    req0 = 1'b1;
    wait_strobe(n);
    check("req_to_strobe", 64'(n), 64'd1);
    repeat (2) @(negedge clk);
    ph_strobe = 1'b1; ph_resp = 38'h01_2345_6789;
    @(negedge clk);
    ph_strobe = 1'b0;
    check("ack_level", 64'(p_ack), 64'd1);
    ph_ack = 1'b1;
    @(negedge clk);
    ph_ack = 1'b0;
    wait_done();
    req0 = 1'b0;
    check("done_ack_low", 64'(p_ack), 64'd0);
    @(negedge clk);

    // response timeout; requester drops iReq mid-transaction
    rp = rst_pulses;
    push(1'b0, CA, '0, 1'b1);
    req0 = 1'b1;
    wait_strobe(n);
    req0 = 1'b0;
    n = 0;
    while (!p_reset && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rsp_abort_lat", 64'(n), 64'd9);
    @(negedge clk);
    check("reset_pulse_w", 64'(p_reset), 64'd0);
    wait_done();
    check("rsp_abort_cnt", 64'(rst_pulses - rp), 64'd1);
    @(negedge clk);

    // ack timeout from requester 1
    rp = rst_pulses;
    push(1'b1, CB, '0, 1'b1);
    req1 = 1'b1;
    phy(1, 38'h15_5555_5555, 0, 1'b0);
    req1 = 1'b0;
    n = 0;
    while (p_ack && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("ack_high_cycles", 64'(n), 64'd8);
    check("ack_abort_reset", 64'(p_reset), 64'd1);
    wait_done();
    check("ack_abort_cnt", 64'(rst_pulses - rp), 64'd1);
    @(negedge clk);

    // events in the final cycle of each wait beat the watchdog
    rp = rst_pulses;
    push(1'b0, CA, 38'h2A_0F0F_0F0F, 1'b0);
    req0 = 1'b1;
    phy(8, 38'h2A_0F0F_0F0F, 8, 1'b1);
    wait_done();
    req0 = 1'b0;
    check("race_no_abort", 64'(rst_pulses - rp), 64'd0);
    @(negedge clk);

    // reset during WAIT_ACK, then a lone pending req1 is granted
    iq.push_back('{w: 1'b0, cmd: CA});
    req0 = 1'b1;
    phy(1, 38'h07_7777_7777, 0, 1'b0);
    check("pre_rst_ack", 64'(p_ack), 64'd1);
    req1 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", 64'({gnt0, gnt1, done0, done1, tmo,
                               p_strobe, p_ack, p_reset}), 64'd0);
    check("mid_rst_cmd", 64'(p_cmd), 64'd0);
    req0 = 1'b0;
    @(negedge clk);
    push(1'b1, CB, 38'h09_9999_9999, 1'b0);
    rst_n = 1'b1;
    phy(2, 38'h09_9999_9999, 1, 1'b1);
    wait_done();
    req1 = 1'b0;
    repeat (3) @(negedge clk);

    check("iq_drained", 64'(iq.size()), 64'd0);
    check("dq_drained", 64'(dq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
